// File: rtl/gb_clock_pkg.sv
// Shared Game Boy clocking definitions: speed-mode encodings and the phase-increment calculation.
// The speed-mode constants are also used by the KEY1 register logic.
package gb_clock_pkg;

    localparam logic SPEED_NORMAL = 1'b0;
    localparam logic SPEED_DOUBLE = 1'b1;

    // Rounded to nearest so the long-run rate has no systematic bias.
    function automatic logic [63:0] gb_calc_inc(
        input longint unsigned sys_clk,
        input longint unsigned gb_clk,
        input int unsigned     acc_width
    );
        logic [63:0] num;
        num = (64'(gb_clk) << acc_width) + (64'(sys_clk) >> 1);
        return num / 64'(sys_clk);
    endfunction

endpackage

// File: rtl/gb_clock_enable_gen_phase_accumulator.sv
// Phase accumulator: adds inc on every enabled sclk and flags the carry-out one cycle later.
module phase_accumulator #(
    parameter int unsigned ACC_WIDTH = 32
) (
    input  logic                 sclk,
    input  logic                 reset,
    input  logic                 en,
    input  logic [ACC_WIDTH-1:0] inc,
    output logic [ACC_WIDTH-1:0] acc,
    output logic                 wrap
);

    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                 wrap_q, wrap_d;
    logic [ACC_WIDTH:0]   sum;

    always_comb begin
        sum    = {1'b0, acc_q} + {1'b0, inc};
        acc_d  = acc_q;
        wrap_d = 1'b0;
        if (en) begin
            acc_d  = sum[ACC_WIDTH-1:0];
            wrap_d = sum[ACC_WIDTH];
        end
    end

    always_ff @(posedge sclk) begin
        if (reset) begin
            acc_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            wrap_q <= wrap_d;
        end
    end

    assign acc  = acc_q;
    assign wrap = wrap_q;

endmodule

// File: rtl/gb_clock_enable_gen.sv
// Fractional T-/M-cycle clock-enable generator with CGB double-speed switching and STOP freeze.
// Mode changes are applied only on an M-cycle boundary and acknowledged with a one-cycle pulse.
module gb_clock_enable_gen
    import gb_clock_pkg::*;
#(
    parameter int unsigned SYSTEM_CLOCK  = 25000000,
    parameter int unsigned GAMEBOY_CLOCK = 4194304,
    parameter int unsigned ACC_WIDTH     = 32
) (
    input  logic sclk,
    input  logic reset,
    input  logic stop,
    input  logic speedReq,
    output logic speedMode,
    output logic speedAck,
    output logic tce,
    output logic mce,
    output logic gclk
);

    localparam logic [63:0] INC1_FULL = gb_calc_inc(64'(SYSTEM_CLOCK), 64'(GAMEBOY_CLOCK),
                                                    ACC_WIDTH);
    localparam logic [63:0] INC2_FULL = INC1_FULL << 1;
    localparam logic [ACC_WIDTH-1:0] INC1 = INC1_FULL[ACC_WIDTH-1:0];
    localparam logic [ACC_WIDTH-1:0] INC2 = INC2_FULL[ACC_WIDTH-1:0];

    // Double speed must still produce at most one wrap per sclk.
    if (ACC_WIDTH > 62 || INC2_FULL >= (64'd1 << ACC_WIDTH)) begin : g_bad_params
        $error("gb_clock_enable_gen: SYSTEM_CLOCK must exceed 2*GAMEBOY_CLOCK");
    end

    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] inc;
    logic                 wrap;
    logic [1:0]           tcnt_q, tcnt_d;
    logic                 speed_mode_q, speed_mode_d;
    logic                 speed_ack_q, speed_ack_d;
    logic                 mce_w;

    assign inc = (speed_mode_q == SPEED_DOUBLE) ? INC2 : INC1;

    phase_accumulator #(
        .ACC_WIDTH (ACC_WIDTH)
    ) u_phase_acc (
        .sclk  (sclk),
        .reset (reset),
        .en    (~stop),
        .inc   (inc),
        .acc   (acc),
        .wrap  (wrap)
    );

    assign mce_w = wrap && (tcnt_q == 2'd3);

    always_comb begin
        tcnt_d       = tcnt_q;
        speed_mode_d = speed_mode_q;
        speed_ack_d  = 1'b0;
        if (wrap) begin
            tcnt_d = tcnt_q + 2'd1;
        end
        // A request that reverts before the M-cycle boundary is never seen here.
        if (mce_w && !stop && (speedReq != speed_mode_q)) begin
            speed_mode_d = speedReq;
            speed_ack_d  = 1'b1;
        end
    end

    always_ff @(posedge sclk) begin
        if (reset) begin
            tcnt_q       <= 2'd0;
            speed_mode_q <= SPEED_NORMAL;
            speed_ack_q  <= 1'b0;
        end else begin
            tcnt_q       <= tcnt_d;
            speed_mode_q <= speed_mode_d;
            speed_ack_q  <= speed_ack_d;
        end
    end

    assign tce       = wrap;
    assign mce       = mce_w;
    assign gclk      = acc[ACC_WIDTH-1];
    assign speedMode = speed_mode_q;
    assign speedAck  = speed_ack_q;

endmodule

// File: tb/tb_gb_clock_enable_gen.sv
// Directed bench: small-parameter instance for exact cycle patterns, default instance for long-run rate.
module tb_gb_clock_enable_gen;

    logic sclk;
    logic reset;
    logic reset_def;
    logic stop;
    logic speed_req;

    logic speed_mode, speed_ack, tce, mce, gclk;
    logic def_mode, def_ack, def_tce, def_mce, def_gclk;
    logic [7:0] acc_obs;

    int checks   = 0;
    int failures = 0;

    gb_clock_enable_gen #(
        .SYSTEM_CLOCK  (100),
        .GAMEBOY_CLOCK (25),
        .ACC_WIDTH     (8)
    ) u_dut (
        .sclk      (sclk),
        .reset     (reset),
        .stop      (stop),
        .speedReq  (speed_req),
        .speedMode (speed_mode),
        .speedAck  (speed_ack),
        .tce       (tce),
        .mce       (mce),
        .gclk      (gclk)
    );

    gb_clock_enable_gen u_def (
        .sclk      (sclk),
        .reset     (reset_def),
        .stop      (1'b0),
        .speedReq  (1'b0),
        .speedMode (def_mode),
        .speedAck  (def_ack),
        .tce       (def_tce),
        .mce       (def_mce),
        .gclk      (def_gclk)
    );

    assign acc_obs = u_dut.u_phase_acc.acc;

    initial begin
        sclk = 1'b0;
        forever #5 sclk = ~sclk;
    end

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        int tcnt_def;
        int mcnt_def;
        int last_tce;
        int gap;

        reset     = 1'b1;
        reset_def = 1'b1;
        stop      = 1'b0;
        speed_req = 1'b0;
        repeat (3) tick();
        chk("rst_tce", tce, 0);
        chk("rst_mce", mce, 0);
        chk("rst_gclk", gclk, 0);
        chk("rst_mode", speed_mode, 0);
        chk("rst_ack", speed_ack, 0);
        chk("rst_acc", acc_obs, 0);

        // Normal speed, INC1=64: tce every 4, mce every 16, gclk 2 high / 2 low.
        reset = 1'b0;
        for (int n = 1; n <= 32; n++) begin
            tick();
            chk("run_tce", tce, (n % 4) == 0);
            chk("run_mce", mce, (n % 16) == 0);
            chk("run_gclk", gclk, (n % 4) >= 2);
        end

        // Freeze with acc=64: three edges remain until the next wrap.
        tick();
        chk("pre_stop_acc", acc_obs, 64);
        stop = 1'b1;
        for (int i = 0; i < 37; i++) begin
            tick();
            chk("stop_tce", tce, 0);
            chk("stop_mce", mce, 0);
            chk("stop_acc", acc_obs, 64);
            chk("stop_gclk", gclk, 0);
        end
        stop = 1'b0;
        tick();
        chk("resume_tce_1", tce, 0);
        tick();
        chk("resume_tce_2", tce, 0);
        tick();
        chk("resume_tce_3", tce, 1);

        // Request raised then withdrawn inside one M-cycle: no switch.
        for (int n = 37; n <= 50; n++) begin
            tick();
            chk("revert_tce", tce, (n % 4) == 0);
            chk("revert_mce", mce, (n % 16) == 0);
            chk("revert_mode", speed_mode, 0);
            chk("revert_ack", speed_ack, 0);
            if (n == 38) speed_req = 1'b1;
            if (n == 42) speed_req = 1'b0;
        end

        // Pending switch discarded by reset landing on its mce.
        speed_req = 1'b1;
        for (int n = 51; n <= 64; n++) begin
            tick();
            chk("pend_mode", speed_mode, 0);
            chk("pend_ack", speed_ack, 0);
        end
        chk("pend_mce", mce, 1);
        reset = 1'b1;
        tick();
        chk("rstsw_mode", speed_mode, 0);
        chk("rstsw_ack", speed_ack, 0);
        chk("rstsw_acc", acc_obs, 0);
        chk("rstsw_tce", tce, 0);
        chk("rstsw_mce", mce, 0);
        chk("rstsw_gclk", gclk, 0);
        speed_req = 1'b0;
        tick();
        chk("rstsw_mode2", speed_mode, 0);
        chk("rstsw_ack2", speed_ack, 0);

        // Switch requested mid-M-cycle; applied after the mce at edge 16.
        reset = 1'b0;
        for (int n = 1; n <= 34; n++) begin
            tick();
            chk("sw_mode", speed_mode, n >= 17);
            chk("sw_ack", speed_ack, n == 17);
            if (n <= 16) begin
                chk("sw_tce_n", tce, (n % 4) == 0);
                chk("sw_gclk_n", gclk, (n % 4) >= 2);
            end else begin
                chk("sw_tce_d", tce, (n >= 19) && ((n % 2) == 1));
                chk("sw_gclk_d", gclk, (n % 2) == 0);
            end
            chk("sw_mce", mce, (n == 16) || (n == 25) || (n == 33));
            if (n == 6) speed_req = 1'b1;
        end

        // Default parameters: first tce after edge 6, gaps 5/6, exact count over 50000 edges.
        tcnt_def  = 0;
        mcnt_def  = 0;
        last_tce  = 0;
        reset_def = 1'b0;
        for (int m = 1; m <= 50000; m++) begin
            tick();
            if (m <= 6) chk("def_first_tce", def_tce, m == 6);
            if (def_tce) begin
                tcnt_def++;
                if (last_tce > 0) begin
                    gap = m - last_tce;
                    chk("def_gap_5_or_6", (gap == 5) || (gap == 6), 1);
                end
                last_tce = m;
            end
            if (def_mce) mcnt_def++;
        end
        chk("def_tce_count", tcnt_def, 8388);
        chk("def_mce_count", mcnt_def, tcnt_def / 4);
        chk("def_mode", def_mode, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gb_clock_enable_gen.md
# gb_clock_enable_gen

Parametrised fractional clock-enable generator: the next-generation Game Boy clock source. A phase accumulator produces an average 4.194304 MHz T-cycle enable from any system clock. It also provides an M-cycle enable (T/4), CGB double-speed mode with a handshaked switch applied only on M-cycle boundaries, and a STOP freeze. It sits at the top of the core and drives every clock-enabled block; downstream logic runs on sclk gated by `tce`/`mce`.

## Interface
Parameters:
- `SYSTEM_CLOCK`, 25000000, sclk frequency in Hz.
- `GAMEBOY_CLOCK`, 4194304, normal-speed T-cycle rate in Hz.
- `ACC_WIDTH`, 32, phase accumulator width in bits.

Ports (reset reset, synchronous, active-high; clock sclk):
- `sclk`  in  1  system clock.
- `reset`  in  1  synchronous active-high reset.
- `stop`  in  1  level; freezes accumulator and all enables while high.
- `speedReq`  in  1  level; 0 = normal, 1 = double speed.
- `speedMode`  out  1  currently applied mode.
- `speedAck`  out  1  one-cycle pulse when a mode change takes effect.
- `tce`  out  1  T-cycle enable, one sclk wide.
- `mce`  out  1  M-cycle enable, one sclk wide, coincident with every 4th `tce`.
- `gclk`  out  1  registered square wave at T-cycle rate, for debug/pins only.

## Operation
- Increments:
  - `INC1 = round(GAMEBOY_CLOCK * 2^ACC_WIDTH / SYSTEM_CLOCK)`.
  - `INC2 = 2*INC1`.
  - Elaboration error if `INC2 >= 2^ACC_WIDTH`, i.e. SYSTEM_CLOCK must exceed 2×GAMEBOY_CLOCK.
- Accumulator update: each sclk with `stop`=0, `acc <= acc + (speedMode ? INC2 : INC1)`, computed at ACC_WIDTH+1 bits. The carry-out is the wrap.
- `tce` is registered. It is 1 in exactly the cycle following an edge on which the accumulator wrapped, else 0.
- `tcnt`, 2 bits, increments on each `tce`. `mce = tce && tcnt==3` (pre-increment value), so `mce` coincides with the 4th, 8th, … `tce`.
- `gclk = acc[ACC_WIDTH-1]`, taken directly from the register; never combinational.
- Speed switch:
  - Pending when `speedReq != speedMode`.
  - Applied only on a cycle where `mce`=1. Next edge: `speedMode <= speedReq`, `speedAck`=1 for one cycle.
  - `acc` and `tcnt` are not cleared by a switch; the new increment starts on the edge after `mce`.
  - If `speedReq` reverts before an `mce`, nothing happens and no ack is issued.
- Stop:
  - While `stop`=1: `acc` and `tcnt` hold, and `tce`/`mce`/`speedAck` are 0. Pending switches wait.
  - On release, accumulation resumes from the held phase.
- Reset is synchronous and has priority over everything, including mid-switch and stop. Reset values: `acc`=0, `tcnt`=0, `speedMode`=0, `speedAck`=0, `tce`=0, `mce`=0, `gclk`=0.

## Timing
- Edge numbering: after reset deasserts, the k-th rising edge gives `acc = k*INC mod 2^ACC_WIDTH`.
- First `tce`: the cycle after edge `ceil(2^ACC_WIDTH / INC1)`. With default parameters (`INC1`=720575940) that is edge 6.
- Long-run rate: the number of `tce` over N sclk cycles is within ±1 of `N*INC/2^ACC_WIDTH`, with no cumulative drift.
- Gap between `tce` pulses is `floor` or `ceil` of `SYSTEM_CLOCK/rate`; never two `tce` in adjacent cycles.
- `speedAck` latency: one cycle after the `mce` that applies the switch. `speedMode` changes on the same edge.
- `stop`: on the edge where `stop` is sampled high, the register holds. No `tce` appears in the following cycle, even if that edge would have wrapped.

## Structure
- Shared package `gb_clock_pkg`:
  - function computing the INC values from `SYSTEM_CLOCK`/`GAMEBOY_CLOCK`/`ACC_WIDTH`;
  - speed-mode constants `SPEED_NORMAL`=0 and `SPEED_DOUBLE`=1, reused by the KEY1 register logic.
- One natural sub-module, `phase_accumulator`:
  - inputs: `en`, `inc`;
  - outputs: `acc` and registered `wrap`.
- The top level holds `tcnt`, the speed-switch logic and the output registers.

## Test plan
- Reset, with `SYSTEM_CLOCK`=100, `GAMEBOY_CLOCK`=25, `ACC_WIDTH`=8 (`INC1`=64): `tce` exactly every 4 cycles, first after edge 4. `mce` every 16 cycles. `gclk` 2 high / 2 low. All outputs 0 during reset.
- Same parameters, `speedReq`=1 set mid-M-cycle: no change until the next `mce`. `speedAck` pulses once, `speedMode`=1. `tce` is then every 2 cycles and `mce` every 8.
- Defaults (25 MHz), run 25,000,000 cycles: `tce` count = 4194304 ±1. Every gap is 5 or 6 cycles.
- `stop`=1 for 37 cycles mid-stream: no `tce`/`mce`, `acc` constant. After release, the next `tce` arrives exactly as many cycles later as were remaining at freeze.
- `speedReq` toggled 1 then back to 0 within one M-cycle: no `speedAck`, `speedMode` stays 0.
- `reset` asserted on the same cycle as an `mce` with a pending switch: `speedMode`=0, `speedAck`=0, `acc`=0 next cycle. The switch is discarded.
